// File: rtl/lh_pkg.sv
// Shared constants, state encoding and helpers for the light-hash sequencer.
// LH_SEQ_ERR_STICKY_EN (see lh_hash_sequencer) does not affect this package.
package lh_pkg;

  localparam logic [63:0] LH_IV          = 64'h34550F14DAC02BEE;
  localparam logic [7:0]  LH_START_CHAR  = 8'hFF;
  localparam logic [7:0]  LH_FINISH_CHAR = 8'h00;

  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_ROUND} lh_seq_state_t;

  function automatic logic [7:0] iv_byte(input int unsigned k);
    return LH_IV[63-8*k -: 8];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] amt);
    logic [15:0] d;
    d = {b, b} << amt;
    return d[15:8];
  endfunction

  function automatic logic is_valid_char(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h5A) ||
           (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_affine(input logic [7:0] b);
    return b ^ rotl8(b, 3'd1) ^ rotl8(b, 3'd2) ^ rotl8(b, 3'd3) ^ rotl8(b, 3'd4) ^ 8'h63;
  endfunction

  // Slow S-box by inverse search; reference use only.
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return aes_affine(inv);
  endfunction

  // Digest of a character string (first char in the MSBs of the n used bytes).
  function automatic logic [63:0] lh_ref_digest(input logic [63:0] chars,
                                                input int unsigned n,
                                                input int unsigned rounds);
    logic [7:0]  h [8];
    logic [7:0]  c;
    logic [63:0] d;
    for (int k = 0; k < 8; k++) h[k] = iv_byte(k);
    for (int unsigned j = 0; j < n; j++) begin
      c = chars[8*(n-1-j) +: 8];
      if (is_valid_char(c))
        for (int unsigned r = 0; r < rounds; r++)
          for (int i = 0; i < 8; i++)
            h[i] = ref_sbox(rotl8(h[(i+2)%8] ^ c, 3'(i)));
    end
    for (int k = 0; k < 8; k++) d[63-8*k -: 8] = h[k];
    return d;
  endfunction

endpackage

// File: rtl/lh_sbox.sv
// Combinational AES S-box: inverse as x^254 by square-and-multiply, then affine map.
module lh_sbox
  import lh_pkg::*;
(
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);

  logic [7:0] w_p;
  logic [7:0] w_inv;

  always_comb begin
    w_p   = i_x;
    w_inv = 8'h01;
    // 254 = 2+4+...+128; zero maps to zero naturally.
    for (int k = 1; k < 8; k++) begin
      w_p   = gf_mul(w_p, w_p);
      w_inv = gf_mul(w_inv, w_p);
    end
    o_y = aes_affine(w_inv);
  end

endmodule

// File: rtl/lh_hash_sequencer.sv
// Sequenced light-hash core: framed char stream in, one S-box update per cycle.
// Define LH_SEQ_ERR_STICKY_EN to make an invalid char poison the open message.
module lh_hash_sequencer
  import lh_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_ptxt_char,
  input  logic        i_ptxt_valid,
  output logic        o_ptxt_ready,
  output logic [63:0] o_digest,
  output logic        o_digest_valid,
  output logic        o_busy,
  output logic        o_err_invalid_ptxt_char
);

  localparam logic [7:0] LAST_R = 8'(ROUNDS - 1);

  lh_seq_state_t r_state;
  logic [7:0]    r_h [8];
  logic [7:0]    r_c;
  logic [2:0]    r_i;
  logic [7:0]    r_r;
  logic          r_ready;
  logic          r_busy;
  logic          r_dv;
  logic          r_err;
  logic [63:0]   r_digest;

  logic          w_xfer;
  logic          w_blocked;
  logic [7:0]    w_t;
  logic [7:0]    w_sb;
  logic [63:0]   w_h_flat;

`ifdef LH_SEQ_ERR_STICKY_EN
  logic r_sticky;
  assign w_blocked = r_sticky;
`else
  assign w_blocked = 1'b0;
`endif

  assign w_xfer = i_ptxt_valid & r_ready;
  assign w_t    = rotl8(r_h[r_i + 3'd2] ^ r_c, r_i);

  always_comb begin
    w_h_flat = '0;
    for (int k = 0; k < 8; k++) w_h_flat[63-8*k -: 8] = r_h[k];
  end

  lh_sbox u_sbox (.i_x(w_t), .o_y(w_sb));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      for (int k = 0; k < 8; k++) r_h[k] <= iv_byte(k);
      r_c      <= '0;
      r_i      <= '0;
      r_r      <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_dv     <= 1'b0;
      r_err    <= 1'b0;
      r_digest <= '0;
`ifdef LH_SEQ_ERR_STICKY_EN
      r_sticky <= 1'b0;
`endif
    end else begin
      r_dv  <= 1'b0;
      r_err <= w_blocked;
      case (r_state)
        ST_IDLE: if (w_xfer) begin
          if (i_ptxt_char == LH_START_CHAR) begin
            for (int k = 0; k < 8; k++) r_h[k] <= iv_byte(k);
            r_state <= ST_OPEN;
`ifdef LH_SEQ_ERR_STICKY_EN
            r_sticky <= 1'b0;
            r_err    <= 1'b0;
`endif
          end else begin
            r_err <= 1'b1;
          end
        end
        ST_OPEN: if (w_xfer) begin
          if (i_ptxt_char == LH_START_CHAR) begin
            for (int k = 0; k < 8; k++) r_h[k] <= iv_byte(k);
`ifdef LH_SEQ_ERR_STICKY_EN
            r_sticky <= 1'b0;
            r_err    <= 1'b0;
`endif
          end else if (i_ptxt_char == LH_FINISH_CHAR) begin
            r_digest <= w_blocked ? '0 : w_h_flat;
            r_dv     <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (is_valid_char(i_ptxt_char)) begin
            // A poisoned message still consumes chars, it just skips the rounds.
            if (!w_blocked) begin
              r_c     <= i_ptxt_char;
              r_i     <= '0;
              r_r     <= '0;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_ROUND;
            end
          end else begin
            r_err <= 1'b1;
`ifdef LH_SEQ_ERR_STICKY_EN
            r_sticky <= 1'b1;
`endif
          end
        end
        ST_ROUND: begin
          r_h[r_i] <= w_sb;
          r_i      <= r_i + 3'd1;
          if (r_i == 3'd7) begin
            r_r <= r_r + 8'd1;
            if (r_r == LAST_R) begin
              r_state <= ST_OPEN;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Masked during reset so no source sees a ready it cannot use.
  assign o_ptxt_ready            = r_ready & ~i_rst;
  assign o_digest                = r_digest;
  assign o_digest_valid          = r_dv;
  assign o_busy                  = r_busy;
  assign o_err_invalid_ptxt_char = r_err;

endmodule

// File: tb/tb_lh_hash_sequencer.sv
// Bench for lh_hash_sequencer: framed message vectors against a byte-stream model.
module tb_lh_hash_sequencer;
  import lh_pkg::*;

  localparam int R = 32;
  localparam int PH = 8 * R;
  localparam logic [63:0] TB_IV = 64'h34550F14DAC02BEE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv  = 1'b0;
  logic [7:0]  pc  = 8'h00;
  logic        prdy, dv, busy, err;
  logic [63:0] dig;

  always #5 clk = ~clk;

  lh_hash_sequencer #(.ROUNDS(R)) dut (
    .i_clk(clk), .i_rst(rst), .i_ptxt_char(pc), .i_ptxt_valid(pv),
    .o_ptxt_ready(prdy), .o_digest(dig), .o_digest_valid(dv), .o_busy(busy),
    .o_err_invalid_ptxt_char(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb [256];

  // Free-running activity counters; the main process works with deltas.
  int busy_cyc = 0, rdy_low = 0, dv_cnt = 0, phases = 0, err_cyc = 0;
  logic busy_q = 1'b0;
  logic [63:0] dig_cap = '0;
  always @(negedge clk) if (!rst) begin
    if (busy) busy_cyc++;
    if (!prdy) rdy_low++;
    if (dv) begin dv_cnt++; dig_cap = dig; end
    if (busy && !busy_q) phases++;
    if (err) err_cyc++;
    busy_q = busy;
  end

  int b_busy, b_rdy, b_dv, b_ph, b_err;
  task automatic snap();
    b_busy = busy_cyc; b_rdy = rdy_low; b_dv = dv_cnt; b_ph = phases; b_err = err_cyc;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // ---- reference model: plain GF arithmetic and byte-stream rules ----
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    int x, p;
    x = int'(a); p = 0;
    for (int k = 0; k < 8; k++) begin
      if (((int'(b) >> k) & 1) == 1) p = p ^ x;
      x = x << 1;
      if (x > 255) x = (x ^ 'h11B);
    end
    return 8'(p);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [7:0] tb_rot(input logic [7:0] x, input int n);
    int v;
    v = (int'(x) << n) | (int'(x) >> (8 - n));
    return 8'(v);
  endfunction

  function automatic bit tb_valid(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "Z") || (b >= "a" && b <= "z");
  endfunction

  function automatic void model(input logic [63:0] bs, input int n, output logic [63:0] d,
                                output int ph, output int drops, output bit st);
    logic [7:0] h [8];
    logic [7:0] b;
    bit open;
    open = 0; st = 0; ph = 0; drops = 0; d = '0;
    for (int k = 0; k < 8; k++) h[k] = TB_IV[63-8*k -: 8];
    for (int j = 0; j < n; j++) begin
      b = bs[8*(n-1-j) +: 8];
      if (!open) begin
        if (b == 8'hFF) begin
          open = 1; st = 0;
          for (int k = 0; k < 8; k++) h[k] = TB_IV[63-8*k -: 8];
        end else drops++;
      end else if (b == 8'hFF) begin
        st = 0;
        for (int k = 0; k < 8; k++) h[k] = TB_IV[63-8*k -: 8];
      end else if (b == 8'h00) begin
        for (int k = 0; k < 8; k++) d[63-8*k -: 8] = st ? 8'h00 : h[k];
        open = 0;
      end else if (tb_valid(b)) begin
        if (!st) begin
          ph++;
          for (int r = 0; r < R; r++)
            for (int i = 0; i < 8; i++) h[i] = sb[tb_rot(h[(i+2)%8] ^ b, i)];
        end
      end else begin
        drops++;
`ifdef LH_SEQ_ERR_STICKY_EN
        st = 1;
`endif
      end
    end
  endfunction

  // ---- stimulus ----
  task automatic do_reset(input string nm);
    tick(); rst = 1'b1; pv = 1'b1; pc = 8'h41;
    tick();
    chk({nm, ".rst_ready"}, 64'(prdy), 64'd0);
    chk({nm, ".rst_out"}, {dig[61:0], dv, busy}, 64'd0);
    chk({nm, ".rst_err"}, 64'(err), 64'd0);
    tick(); rst = 1'b0; pv = 1'b0; #1;
    chk({nm, ".rel_ready"}, 64'(prdy), 64'd1);
  endtask

  task automatic send(input string nm, input logic [7:0] b);
    int cnt;
    pv = 1'b1; pc = b; cnt = 0;
    while (!prdy && cnt < 4000) begin tick(); cnt++; end
    if (cnt >= 4000) chk({nm, ".ready_timeout"}, 64'd0, 64'd1);
    tick();
  endtask

  typedef struct { string nm; logic [63:0] bs; int n; } vec_t;

  task automatic run_vec(input vec_t v);
    logic [63:0] ed;
    int eph, edr;
    bit est;
    do_reset(v.nm);
    snap();
    for (int j = 0; j < v.n; j++) send(v.nm, v.bs[8*(v.n-1-j) +: 8]);
    pv = 1'b0;
    repeat (4) tick();
    model(v.bs, v.n, ed, eph, edr, est);
    chk({v.nm, ".dv_pulses"}, 64'(dv_cnt - b_dv), 64'd1);
    chk({v.nm, ".digest"}, dig_cap, ed);
    chk({v.nm, ".round_phases"}, 64'(phases - b_ph), 64'(eph));
    chk({v.nm, ".busy_cycles"}, 64'(busy_cyc - b_busy), 64'(eph * PH));
    chk({v.nm, ".ready_low"}, 64'(rdy_low - b_rdy), 64'(eph * PH));
    chk({v.nm, ".err_level"}, 64'(err), 64'(est));
`ifndef LH_SEQ_ERR_STICKY_EN
    chk({v.nm, ".err_cycles"}, 64'(err_cyc - b_err), 64'(edr));
`endif
  endtask

  vec_t vecs [5];
  logic [7:0] bad [8];

  initial begin
    build_sbox();
    bad = '{8'h23, 8'h20, 8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h7B, 8'hFE};
    vecs[0] = '{"msgA",    64'hFF_41_00,          3};
    vecs[1] = '{"msgZ9Q",  64'hFF_7A_39_51_00,    5};
    vecs[2] = '{"msgAhB",  64'hFF_41_23_42_00,    5};
    vecs[3] = '{"reopen",  64'hFF_41_FF_42_00,    5};
    vecs[4] = '{"idle_x",  64'h78_FF_00,          3};

    for (int k = 0; k < 5; k++) begin
      run_vec(vecs[k]);
      if (k == 0) chk("msgA.pkg_ref", dig_cap, lh_ref_digest(64'h41, 1, R));
    end

    // Abort mid-ROUND, then an empty message must yield the IV.
    do_reset("abort");
    send("abort", 8'hFF);
    send("abort", 8'h41);
    pv = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.ready", 64'(prdy), 64'd1);
    chk("abort.digest_clr", dig, 64'd0);
    snap();
    send("abort", 8'hFF);
    send("abort", 8'h00);
    pv = 1'b0;
    repeat (3) tick();
    chk("abort.dv", 64'(dv_cnt - b_dv), 64'd1);
    chk("abort.digest_iv", dig_cap, 64'h34550F14DAC02BEE);

    // Randomized framed messages.
    for (int t = 0; t < 6; t++) begin
      vec_t v;
      int nc, r, idx;
      logic [7:0] b;
      nc = $urandom_range(1, 4);
      v.nm = $sformatf("rand%0d", t);
      v.n = nc + 2;
      v.bs = 64'hFF;
      for (int j = 0; j < nc; j++) begin
        r = $urandom_range(0, 9);
        if (r < 7) begin
          idx = $urandom_range(0, 61);
          if (idx < 10) b = 8'(8'h30 + idx);
          else if (idx < 36) b = 8'(8'h41 + idx - 10);
          else b = 8'(8'h61 + idx - 36);
        end else if (r < 9) b = bad[$urandom_range(0, 7)];
        else b = 8'hFF;
        v.bs = {v.bs[55:0], b};
      end
      v.bs = {v.bs[55:0], 8'h00};
      run_vec(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lh_hash_sequencer.md
# lh_hash_sequencer

Iterative controller for the light-hash datapath. It accepts one plaintext character at a time over a valid/ready handshake and frames messages with start (8'hFF) and finish (8'h00) bytes. For each accepted alphanumeric character it runs ROUNDS×8 digest-byte updates, one per cycle, through a single shared AES S-box instance. It sits between the character source and any digest consumer, and replaces the fully unrolled combinational hash with a small sequenced core.

## Interface
- ROUNDS, 32, rounds per character; legal range 1..255.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ptxt_char  in  8  character, or framing byte 8'hFF / 8'h00.
- ptxt_valid  in  1  ptxt_char is valid this cycle.
- ptxt_ready  out  1  sequencer accepts a byte; a transfer occurs when ptxt_valid && ptxt_ready.
- digest  out  64  {H[0],…,H[7]}, with H[0] in bits 63:56; registered and held until the next finish or reset.
- digest_valid  out  1  one-cycle pulse when digest updates.
- busy  out  1  high while rounds are running.
- err_invalid_ptxt_char  out  1  invalid-character flag; behaviour set by the macro below.

## Operation
- State H[0..7] holds 8 registered bytes. The IV is LH_IV = {8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE} for H[0..7].
- A character is valid when it is 0x30–0x39, 0x41–0x5A or 0x61–0x7A.
- FSM states: IDLE, OPEN, ROUND.
- IDLE (ptxt_ready=1):
  - 8'hFF → load H=IV, go to OPEN.
  - Any other byte is consumed and dropped, and err_invalid_ptxt_char pulses.
- OPEN (ptxt_ready=1):
  - 8'hFF → reload IV, stay in OPEN.
  - 8'h00 → digest<=H, digest_valid pulse, go to IDLE.
  - Valid char → latch into c, clear counters, go to ROUND.
  - Invalid char → dropped, error handled per Configuration, stay in OPEN.
- ROUND (ptxt_ready=0, busy=1):
  - Step counter i runs 0..7; round counter r runs 0..ROUNDS-1.
  - Each cycle: t = rotl8(H[(i+2) mod 8] ^ c, i); then H[i] <= SBOX[t].
  - Updates are in place, so steps i=6 and i=7 read H[0] and H[1] as already updated this round.
  - After the update at i=7, r=ROUNDS-1, go to OPEN.
- Counter widths: i is 3 bits and wraps 7→0 with r incrementing. r is 8 bits.
- Reset (any state, including mid-ROUND) aborts the message:
  - state=IDLE, H=IV, counters=0.
  - digest=0, digest_valid=0, busy=0, err_invalid_ptxt_char=0.
  - ptxt_ready=1 in the cycle after rst deasserts.

## Timing
- Character accepted at cycle T: H updates at edges T+1..T+8·ROUNDS. ptxt_ready reasserts at T+8·ROUNDS+1.
- Per-character throughput: 8·ROUNDS+1 cycles (257 for ROUNDS=32).
- Finish accepted at T: digest and digest_valid appear at T+1, and the FSM is in IDLE with ptxt_ready=1 at T+1.
- Start accepted at T: H=IV visible at T+1.
- ptxt_valid while ptxt_ready=0 is ignored. The source must hold the byte; no data is lost.
- err_invalid_ptxt_char asserts at T+1 for a drop at T.
- ptxt_ready is a registered decode of state; it has no combinational path from ptxt_valid.

## Configuration
- LH_SEQ_ERR_STICKY_EN:
  - Undefined: an invalid character produces a one-cycle err pulse, the byte is dropped, and the message continues normally.
  - Defined: an invalid character in OPEN sets a sticky error.
    - err_invalid_ptxt_char stays high until the next accepted 8'hFF or reset.
    - While the error is set, valid characters are consumed without entering ROUND.
    - The finish byte produces digest_valid with digest=64'h0.
  - Invalid bytes in IDLE only pulse in both builds.

## Structure
- Package lh_pkg holds:
  - LH_IV, LH_START_CHAR (8'hFF), LH_FINISH_CHAR (8'h00);
  - state enum lh_seq_state_t;
  - functions rotl8(byte, amt) and is_valid_char(byte);
  - a behavioural reference function for the testbench.
- One sub-module, lh_sbox: a combinational 8-bit AES S-box, instantiated once.
- The FSM, counters and H registers live in lh_hash_sequencer.

## Test plan
- Reset: rst=1 for 2 cycles with ptxt_valid=1 → all outputs 0, ptxt_ready=0 during reset, ptxt_ready=1 on the first cycle after release.
- Message FF,'A'(0x41),00 with ROUNDS=32:
  - ptxt_ready low for exactly 256 cycles after 'A';
  - busy high for those same 256 cycles;
  - digest_valid is a single pulse;
  - digest equals the lh_pkg reference for "A".
- Message FF,'z','9','Q',00 with valid held high the whole time:
  - exactly 3 ROUND phases;
  - the source stalls, with no bytes dropped;
  - digest matches the reference for "z9Q".
- Message FF,'A','#'(0x23),'B',00:
  - without the macro: err pulses once, and digest = reference("AB");
  - with LH_SEQ_ERR_STICKY_EN: err stays high, no ROUND for 'B', digest=64'h0.
- Abort: FF,'A', then rst for 1 cycle at step 100 of the ROUND phase, then FF,00 → digest=LH_IV concatenation (64'h34550F14DAC02BEE).
- Framing: 'x' in IDLE → err pulse, no state change. FF,'A',FF,'B',00 → digest = reference("B").
